// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch (IF) and data (DM) accesses.
// DM wins by default; IF is forced once DM has taken STARVE_LIMIT grants in a row while IF waited.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    // state  | meaning
    // IDLE   | sample requests, grant one
    // ISSUE  | command strobe to memory
    // WAIT   | count down memory latency, capture read data
    // DONE   | ready pulse to owner
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [STREAK_W-1:0] dm_streak;
    logic                owner_dm;
    logic                is_we;
    logic                starve_hit;
    logic                grant_if;
    logic                grant_dm;

    always_comb begin
        starve_hit = (STARVE_LIMIT != 0) && (dm_streak == STREAK_MAX);
        grant_if   = if_req && (!dm_req || starve_hit);
        grant_dm   = dm_req && !grant_if;
    end

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dm_streak <= '0;
            owner_dm  <= 1'b0;
            is_we     <= 1'b0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_ready  <= 1'b0;
            dm_rdata  <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_if) begin
                        owner_dm  <= 1'b0;
                        is_we     <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_valid <= 1'b1;
                        dm_streak <= '0;
                        state     <= S_ISSUE;
                    end else if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        is_we     <= dm_we;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_valid <= 1'b1;
                        state     <= S_ISSUE;
                        // streak only grows while IF is actually being passed over
                        if (!if_req) begin
                            dm_streak <= '0;
                        end else if (dm_streak != STREAK_MAX) begin
                            dm_streak <= dm_streak + STREAK_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (!is_we) begin
                            if (owner_dm) dm_rdata <= mem_rdata;
                            else          if_rdata <= mem_rdata;
                        end
                        if_ready <= !owner_dm;
                        dm_ready <= owner_dm;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level reference predicts grants and timing,
// a memory model answers the DUT, and a negedge monitor compares the DUT against the predictions.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam int LIM = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_ready, if_stall, dm_ready, dm_stall, mem_valid, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          issue;
        int          rdy;
        bit          dm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // reference state (requester levels, arbitration history, memory contents)
    bit   if_pend = 0, dm_pend = 0, clear_q = 0;
    int   if_done = -1, dm_done = -1;
    int   ref_free = 0, streak = 0, last_issue = -10;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [31:0]];
    int          rd_due [$];
    logic [31:0] rd_dat [$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (!ref_mem.exists(a)) ref_mem[a] = init_val(a);
        return ref_mem[a];
    endfunction

    function automatic void preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a] = v;
        env_mem[a] = v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic issue_if(input logic [31:0] a);
        if_pend = 1; if_req = 1; if_addr = a; if_done = -1;
    endtask

    task automatic issue_dm(input bit we, input logic [31:0] a, input logic [31:0] d);
        dm_pend = 1; dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d; dm_done = -1;
    endtask

    // arbitration for the current cycle, applied to the levels the DUT samples this cycle
    task automatic decide();
        txn_t t;
        bit   gi;
        if (reset) begin
            clear_q = 1; streak = 0; ref_free = cyc + 1;
            if_pend = 0; dm_pend = 0; if_req = 0; dm_req = 0;
            if_done = -1; dm_done = -1;
            return;
        end
        if (cyc < ref_free) return;
        gi = if_pend && (!dm_pend || (LIM != 0 && streak == LIM));
        if (!gi && !dm_pend) return;
        t.issue = cyc + 1;
        t.rdy   = cyc + LAT + 2;
        t.dm    = !gi;
        if (gi) begin
            t.addr = if_addr; t.we = 0; t.wdata = 0; t.rdata = ref_rd(if_addr);
            if_done = t.rdy;
            streak = 0;
        end else begin
            t.addr = dm_addr; t.we = dm_we; t.wdata = dm_wdata;
            if (dm_we) begin
                ref_mem[dm_addr] = dm_wdata;
                t.rdata = 0;
            end else begin
                t.rdata = ref_rd(dm_addr);
            end
            dm_done = t.rdy;
            streak = if_pend ? ((streak < LIM) ? streak + 1 : LIM) : 0;
        end
        ref_free   = cyc + LAT + 3;
        last_issue = t.issue;
        q.push_back(t);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (clear_q) begin
            q.delete();
            clear_q = 0;
        end
        if (if_pend && if_done == cyc) begin if_pend = 0; if_req = 0; end
        if (dm_pend && dm_done == cyc) begin dm_pend = 0; dm_req = 0; end
    endtask

    task automatic step();
        decide();
        advance();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (if_pend || dm_pend || cyc < ref_free); i++) step();
        if (if_pend || dm_pend || cyc < ref_free) chk("drain_bound", 1, 0);
        step();
    endtask

    function automatic logic [31:0] pick_addr();
        return 32'h100 + 32'(4 * $urandom_range(0, 5));
    endfunction

    // backing memory: answers exactly LAT cycles after the strobe, noise otherwise
    always @(negedge clk) begin : mem_model
        if (mem_valid === 1'b1) begin
            if (!env_mem.exists(mem_addr)) env_mem[mem_addr] = init_val(mem_addr);
            if (mem_we) begin
                env_mem[mem_addr] = mem_wdata;
            end else begin
                rd_due.push_back(cyc + LAT);
                rd_dat.push_back(env_mem[mem_addr]);
            end
        end
        if (rd_due.size() > 0 && rd_due[0] == cyc) begin
            mem_rdata = rd_dat.pop_front();
            void'(rd_due.pop_front());
        end else begin
            mem_rdata = $urandom();
        end
    end

    txn_t        m_t;
    bit          m_has, e_mv, e_ir, e_dr, e_busy;
    bit          rst_prev = 1;
    logic [31:0] exp_if_rdata = 0, exp_dm_rdata = 0;

    always @(negedge clk) begin : monitor
        if (cyc >= 1) begin
            m_has = (q.size() > 0);
            if (m_has) m_t = q[0];
            e_mv   = m_has && m_t.issue == cyc;
            e_ir   = m_has && m_t.rdy == cyc && !m_t.dm;
            e_dr   = m_has && m_t.rdy == cyc && m_t.dm;
            e_busy = m_has && cyc >= m_t.issue && cyc <= m_t.rdy;
            if (rst_prev) begin
                exp_if_rdata = 0;
                exp_dm_rdata = 0;
                chk("reset_mem_we", mem_we, 0);
                chk("reset_mem_addr", mem_addr, 0);
                chk("reset_mem_wdata", mem_wdata, 0);
            end
            if (mem_valid || e_mv) begin
                chk("mem_valid", mem_valid, e_mv);
                if (e_mv && mem_valid) begin
                    chk("mem_addr", mem_addr, m_t.addr);
                    chk("mem_we", mem_we, m_t.we);
                    if (m_t.we) chk("mem_wdata", mem_wdata, m_t.wdata);
                end
            end
            if (if_ready || e_ir) chk("if_ready", if_ready, e_ir);
            if (dm_ready || e_dr) chk("dm_ready", dm_ready, e_dr);
            if (e_ir) exp_if_rdata = m_t.rdata;
            if (e_dr && !m_t.we) exp_dm_rdata = m_t.rdata;
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("dm_rdata", dm_rdata, exp_dm_rdata);
            chk("if_stall", if_stall, if_req & ~e_ir);
            chk("dm_stall", dm_stall, dm_req & ~e_dr);
            chk("busy", busy, e_busy);
            if (m_has && cyc >= m_t.rdy) void'(q.pop_front());
            rst_prev = reset;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        repeat (3) step();
        reset = 0;

        // single fetch with a known instruction word
        preload(32'h40, 32'h0050_0093);
        issue_if(32'h40);
        drain();

        // simultaneous requests: DM first, then IF
        preload(32'h44, 32'h0010_0113);
        issue_if(32'h44);
        issue_dm(0, 32'h100, 0);
        drain();

        // DM read establishes dm_rdata, DM write must leave it alone, read-back sees the write
        preload(32'h200, 32'h1234_5678);
        issue_dm(0, 32'h200, 0);
        drain();
        issue_dm(1, 32'h100, 32'hDEAD_BEEF);
        drain();
        issue_dm(0, 32'h100, 0);
        drain();

        // both requesters held continuously: starvation limit forces IF periodically
        repeat (8 * (LAT + 3) + 2) begin
            if (!if_pend) issue_if(pick_addr());
            if (!dm_pend) issue_dm(0, pick_addr(), 0);
            step();
        end
        drain();

        // reset during WAIT aborts the access; a following fetch behaves normally
        issue_if(32'h40);
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        step();
        issue_if(32'h40);
        drain();

        // randomized traffic with occasional resets mid-access
        for (int i = 0; i < 500; i++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) issue_if(pick_addr());
            if (!dm_pend && $urandom_range(0, 2) == 0)
                issue_dm(1'($urandom_range(0, 1)), pick_addr(), $urandom());
            if (cyc == last_issue + 1 && $urandom_range(0, 24) == 0) reset = 1;
            step();
            reset = 0;
        end
        drain();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
